// File: rtl/reg_write_arbiter.sv
// Three-requester round-robin arbiter in front of one shared register.
// Each granted write runs IDLE -> LOAD -> ACK and is acknowledged with a 4-phase handshake.
module reg_write_arbiter #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  output logic [2:0]       gnt,
  output logic [2:0]       ack,
  output logic             enable,
  output logic [WIDTH-1:0] d_out,
  output logic [WIDTH-1:0] q,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    ACK  = 2'b10
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [1:0]       last;
  logic [1:0]       last_nx;
  logic [2:0]       gnt_nx;
  logic [2:0]       ack_nx;
  logic             en_nx;
  logic [WIDTH-1:0] dout_nx;
  logic [WIDTH-1:0] q_nx;

  logic [1:0]       p0;
  logic [1:0]       p1;
  logic [1:0]       p2;
  logic [1:0]       win;
  logic             win_vld;
  logic [2:0]       win_oh;
  logic [WIDTH-1:0] win_d;

  // Priority order starts just after the last winner.
  always_comb begin
    p0 = 2'd0;
    p1 = 2'd1;
    p2 = 2'd2;
    case (last)
      2'd0: begin
        p0 = 2'd1;
        p1 = 2'd2;
        p2 = 2'd0;
      end
      2'd1: begin
        p0 = 2'd2;
        p1 = 2'd0;
        p2 = 2'd1;
      end
      default: begin
        p0 = 2'd0;
        p1 = 2'd1;
        p2 = 2'd2;
      end
    endcase
  end

  always_comb begin
    win     = p2;
    win_vld = |req;
    if (req[p0]) begin
      win = p0;
    end else if (req[p1]) begin
      win = p1;
    end else begin
      win = p2;
    end
  end

  always_comb begin
    win_oh = 3'b001 << win;
    case (win)
      2'd0:    win_d = d0;
      2'd1:    win_d = d1;
      default: win_d = d2;
    endcase
  end

  always_comb begin
    state_nx = state;
    last_nx  = last;
    gnt_nx   = gnt;
    ack_nx   = ack;
    en_nx    = 1'b0;
    dout_nx  = d_out;
    q_nx     = q;
    case (state)
      IDLE: begin
        gnt_nx  = 3'b000;
        ack_nx  = 3'b000;
        dout_nx = '0;
        if (win_vld) begin
          state_nx = LOAD;
          gnt_nx   = win_oh;
          dout_nx  = win_d;
          en_nx    = 1'b1;
          last_nx  = win;
        end
      end
      LOAD: begin
        q_nx     = d_out;
        ack_nx   = gnt;
        state_nx = ACK;
      end
      ACK: begin
        // Only the granted requester's line matters here.
        if ((req & gnt) == 3'b000) begin
          gnt_nx   = 3'b000;
          ack_nx   = 3'b000;
          dout_nx  = '0;
          state_nx = IDLE;
        end
      end
      default: begin
        gnt_nx   = 3'b000;
        ack_nx   = 3'b000;
        dout_nx  = '0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      last   <= 2'd2;
      gnt    <= 3'b000;
      ack    <= 3'b000;
      enable <= 1'b0;
      d_out  <= '0;
      q      <= '0;
    end else begin
      state  <= state_nx;
      last   <= last_nx;
      gnt    <= gnt_nx;
      ack    <= ack_nx;
      enable <= en_nx;
      d_out  <= dout_nx;
      q      <= q_nx;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, 7, data width of the shared register.
REQ-002 Port clk SHALL be: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port reset SHALL be: reset  input  1  asynchronous, active-high reset.
REQ-004 Port req SHALL be: req  input  3  per-requester write request (bit i = requester i), level, 4-phase.
REQ-005 Ports d0/d1/d2 SHALL be: dN  input  WIDTH  write data of requester N.
REQ-006 Port gnt SHALL be: gnt  output  3  registered one-hot grant, zero when idle.
REQ-007 Port ack SHALL be: ack  output  3  registered one-hot write-complete acknowledge.
REQ-008 Port enable SHALL be: enable  output  1  registered load strobe of the shared register.
REQ-009 Port d_out SHALL be: d_out  output  WIDTH  data latched from the granted requester.
REQ-010 Port q SHALL be: q  output  WIDTH  shared register contents.
REQ-011 Port busy SHALL be: busy  output  1  high whenever state is not IDLE.

Function
REQ-012 FSM SHALL have states IDLE, LOAD, ACK; 2-bit encoding; no other reachable states (unused encoding -> IDLE next edge).
REQ-013 IDLE, req != 0: SHALL select winner, set gnt one-hot, latch d_out <= d[winner], enable <= 1, go LOAD, all on the same edge.
REQ-014 Arbitration SHALL be round-robin on pointer last[1:0]: priority order (last+1)%3, (last+2)%3, last.
REQ-015 last SHALL update to the winner index on the IDLE->LOAD edge only.
REQ-016 LOAD: enable SHALL be high for exactly one cycle; on the LOAD edge q <= d_out, enable <= 0, ack <= gnt, go ACK.
REQ-017 ACK: state, gnt, ack SHALL hold while req[winner] = 1; on an edge with req[winner] = 0, gnt <= 0, ack <= 0, go IDLE.
REQ-018 IDLE, req == 0: all outputs except q SHALL hold at 0; q SHALL hold.
REQ-019 Latency: req sampled at edge k -> gnt/enable high after k; q updated and ack high after k+1; minimum spacing between grant edges = 3 cycles.
REQ-020 dN SHALL be sampled only at the grant edge; later changes SHALL not affect d_out or q.
REQ-021 req[winner] dropped during LOAD: write SHALL still complete; ack high exactly one cycle, then IDLE.
REQ-022 Requests of non-granted requesters SHALL be ignored (not queued) until return to IDLE.
REQ-023 Fairness: a requester holding req continuously SHALL be granted within 3 grant events.
REQ-024 q SHALL change only on the LOAD->ACK edge or on reset.

Reset
REQ-025 reset high SHALL immediately (no clock) force state IDLE, gnt=0, ack=0, enable=0, d_out=0, q=0, busy=0, last=2.
REQ-026 Reset mid-transaction SHALL abort it; q SHALL be 0, and no enable pulse SHALL follow reset release.
REQ-027 First grant after reset with all req high SHALL go to requester 0.

Verification
REQ-028 Single: req=3'b010, d1=7'h55 -> gnt=010 after 1 edge, enable 1 cycle, q=7'h55 and ack=010 after 2 edges; req drop -> IDLE next edge.
REQ-029 Round-robin: req=3'b111 held, each acks then re-raises -> grant order 0,1,2,0; q = d0,d1,d2,d0.
REQ-030 Data stability: d2=7'h11 at grant edge, d2=7'h7F during LOAD -> q=7'h11.
REQ-031 Early drop: req0 falls during LOAD, d0=7'h2A -> q=7'h2A, ack=001 one cycle, busy low next edge.
REQ-032 Async reset: reset asserted mid-LOAD between edges -> all outputs 0 at once, q=0; next req=3'b100 after release -> gnt=100 (last=2 → requester 0 priority, 0 absent).
REQ-033 Hold: req=3'b001 held in ACK for 5 cycles, req[1] raised meanwhile -> gnt=001 throughout, no enable, requester 1 granted after return to IDLE.
